// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// datapath step mode and the operation decode helpers.
package mul_div_unit_pkg;

  localparam int FUNCT_W = 6;
  typedef logic [FUNCT_W-1:0] funct_t;

  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1a;
  localparam funct_t FUNCT_DIVU  = 6'h1b;

  typedef enum logic {MODE_MUL, MODE_DIV} step_mode_e;

  function automatic logic funct_ok(input funct_t f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic logic funct_signed(input funct_t f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

  function automatic logic funct_div(input funct_t f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage handshake and HI/LO access bundle for mul_div_unit.
interface mul_div_unit_if #(parameter int DATA_WIDTH = 32);
  import mul_div_unit_pkg::*;

  logic                  start;
  funct_t                funct;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  flush;
  logic [1:0]            hilo_we;
  logic [DATA_WIDTH-1:0] hilo_wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, funct, operand_1, operand_2, flush, hilo_we, hilo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, funct, operand_1, operand_2, flush, hilo_we, hilo_wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
// For divide the quotient bit is returned separately; acc_next carries a 0 in its LSB.
module muldiv_step
  import mul_div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  step_mode_e     mode,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);

  logic [W:0]   sum;
  logic [W:0]   part;
  logic [W-1:0] diff;

  always_comb begin
    sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? operand : {W{1'b0}})};
    // Partial remainder is W+1 bits wide; when it fits the divisor the
    // difference is always smaller than the divisor, so W bits suffice.
    part  = {acc[2*W-1:W], acc[W-1]};
    diff  = part[W-1:0] - operand;
    q_bit = (mode == MODE_DIV) && (part >= {1'b0, operand});
    if (mode == MODE_MUL)
      acc_next = {sum, acc[W-1:1]};
    else
      acc_next = {(q_bit ? diff : part[W-1:0]), acc[W-2:0], 1'b0};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; start/busy/done handshake,
// W iterations per operation plus a sign-fix cycle and a done cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_div, is_signed, sign_1, sign_2, div_zero;
  logic [W-1:0]         operand, raw_1;
  logic [2*W-1:0]       acc, step_acc;
  logic                 q_bit;
  logic                 busy, done;
  logic [W-1:0]         hi, lo;

  logic                 accept, sgn_in;
  logic [W-1:0]         mag_1, mag_2;
  logic [2*W-1:0]       prod_fix;
  logic [W-1:0]         quo_fix, rem_fix;

  assign accept = (state == S_IDLE) && bus.start && !bus.flush && funct_ok(bus.funct);
  assign sgn_in = funct_signed(bus.funct);
  assign mag_1  = (sgn_in && bus.operand_1[W-1]) ? -bus.operand_1 : bus.operand_1;
  assign mag_2  = (sgn_in && bus.operand_2[W-1]) ? -bus.operand_2 : bus.operand_2;

  muldiv_step #(.W(W)) u_step (
    .mode     (is_div ? MODE_DIV : MODE_MUL),
    .acc      (acc),
    .operand  (operand),
    .acc_next (step_acc),
    .q_bit    (q_bit)
  );

  // Quotient takes the XOR of the signs; remainder follows the dividend.
  always_comb begin
    prod_fix = (is_signed && (sign_1 ^ sign_2)) ? -acc : acc;
    quo_fix  = (is_signed && (sign_1 ^ sign_2)) ? -acc[W-1:0] : acc[W-1:0];
    rem_fix  = (is_signed && sign_1) ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (state != S_IDLE && bus.flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            is_div    <= funct_div(bus.funct);
            is_signed <= sgn_in;
            sign_1    <= bus.operand_1[W-1];
            sign_2    <= bus.operand_2[W-1];
            div_zero  <= (bus.operand_2 == '0);
            raw_1     <= bus.operand_1;
            // Multiply shifts the multiplier out of the low half; divide
            // shifts the dividend out of it.
            acc       <= {{W{1'b0}}, (funct_div(bus.funct) ? mag_1 : mag_2)};
            operand   <= funct_div(bus.funct) ? mag_2 : mag_1;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= S_CALC;
          end else begin
            if (bus.hilo_we[1]) hi <= bus.hilo_wdata;
            if (bus.hilo_we[0]) lo <= bus.hilo_wdata;
          end
        end
        S_CALC: begin
          acc <= step_acc | {{(2*W-1){1'b0}}, q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end else if (div_zero) begin
            hi <= raw_1;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against a plain-arithmetic model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.DATA_WIDTH(W)) bus ();

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input funct_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     q, r;
    logic [63:0] p;
    h = '0;
    l = '0;
    case (f)
      FUNCT_MULTU: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      FUNCT_MULT:  begin p = 64'(sa * sb);            h = p[63:32]; l = p[31:0]; end
      FUNCT_DIVU:  if (b == 0) begin h = a; l = '1; end else begin h = a % b; l = a / b; end
      FUNCT_DIV:   if (b == 0) begin h = a; l = '1; end
                   else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      default: ;
    endcase
  endfunction

  task automatic hilo_write(input logic [1:0] we, input logic [W-1:0] d);
    bus.hilo_we = we;
    bus.hilo_wdata = d;
    tick();
    bus.hilo_we = 2'b00;
  endtask

  // Runs one operation from acceptance to idle; optionally pulses a stray start
  // while busy at edge poke_at after acceptance.
  task automatic do_op(input string tag, input funct_t f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int poke_at);
    logic [W-1:0] eh, el;
    int n_busy = 0, n_done = 0, first_done = -1;
    model(f, a, b, eh, el);
    bus.funct = f; bus.operand_1 = a; bus.operand_2 = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.operand_1 = $urandom; bus.operand_2 = $urandom;
    for (int e = 0; e <= W + 4; e++) begin
      if (e > 0) tick();
      if (bus.busy) n_busy++;
      if (bus.done) begin n_done++; if (first_done < 0) first_done = e; end
      if (e == poke_at) begin bus.start = 1'b1; bus.funct = FUNCT_MULTU; end
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    chk({tag, "_busy_cycles"}, n_busy, W + 2);
    chk({tag, "_done_edge"}, first_done, W + 1);
    chk({tag, "_done_count"}, n_done, 1);
  endtask

  initial begin
    funct_t       fl [4];
    int           n_done;
    logic [W-1:0] a, b;
    fl[0] = FUNCT_MULT; fl[1] = FUNCT_MULTU; fl[2] = FUNCT_DIV; fl[3] = FUNCT_DIVU;
    bus.start = 1'b0; bus.funct = '0; bus.operand_1 = '0; bus.operand_2 = '0;
    bus.flush = 1'b0; bus.hilo_we = 2'b00; bus.hilo_wdata = '0;

    tick(); tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    rst_n = 1'b1;
    tick();

    hilo_write(2'b11, 32'h0000_ABCD);
    chk("wr_hi", bus.hi, 32'h0000_ABCD);
    chk("wr_lo", bus.lo, 32'h0000_ABCD);

    do_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
    do_op("mult_neg", FUNCT_MULT, -32'sd3, 32'd5, -1);
    do_op("div_neg", FUNCT_DIV, -32'sd7, 32'd2, -1);
    chk("div_neg_lo_const", bus.lo, 32'hFFFF_FFFD);
    do_op("divu_zero", FUNCT_DIVU, 32'd7, 32'd0, -1);
    do_op("div_zero", FUNCT_DIV, -32'sd9, 32'd0, -1);
    do_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_ovf_lo_const", bus.lo, 32'h8000_0000);

    // Flush mid-operation, with a direct write attempted while busy.
    hilo_write(2'b10, 32'h11);
    hilo_write(2'b01, 32'h22);
    bus.funct = FUNCT_DIVU; bus.operand_1 = 32'd100; bus.operand_2 = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      bus.hilo_we = (i == 4) ? 2'b11 : 2'b00;
      bus.hilo_wdata = 32'h55;
      tick();
      if (bus.done) n_done++;
    end
    bus.hilo_we = 2'b00;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    if (bus.done) n_done++;
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_no_done", n_done, 0);
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h22);
    do_op("after_flush", FUNCT_DIVU, 32'd100, 32'd3, -1);

    // Accept wins over a same-cycle direct write.
    hilo_write(2'b11, 32'h77);
    bus.funct = FUNCT_MULTU; bus.operand_1 = 32'd2; bus.operand_2 = 32'd3; bus.start = 1'b1;
    bus.hilo_we = 2'b11; bus.hilo_wdata = 32'h0000_ABCD;
    tick();
    bus.start = 1'b0; bus.hilo_we = 2'b00;
    chk("arb_busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("arb_hi", bus.hi, 32'h77);
    chk("arb_lo", bus.lo, 32'h77);

    // Flush in IDLE blocks a start; unsupported funct is ignored.
    bus.funct = FUNCT_DIVU; bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("idle_flush_blocks", bus.busy, 1'b0);
    bus.funct = 6'h20; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("bad_funct", bus.busy, 1'b0);

    // Reset mid-operation.
    bus.funct = FUNCT_MULTU; bus.operand_1 = 32'h1234; bus.operand_2 = 32'h5678; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_hi", bus.hi, '0);
    chk("midrst_lo", bus.lo, '0);
    rst_n = 1'b1;
    tick();

    // Stray start while busy must not queue a second operation.
    do_op("start_busy", FUNCT_DIV, 32'h0001_0000, -32'sd3, 6);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = W'($urandom_range(1, 9));
        2: b = -W'($urandom_range(1, 9));
        default: b = ($urandom_range(0, 1) != 0) ? '0 : 32'hFFFF_FFFF;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_op("rand", fl[$urandom_range(0, 3)], a, b, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
